// File: rtl/input_vc_scheduler.sv
// Input-port VC scheduler: round-robin switch arbitration across the VC buffers
// of one input port, gated by per-downstream-VC credit counters.
module input_vc_scheduler #(
  parameter int VC_SIZE    = 2,
  parameter int VC_DEPTH   = 4,
  parameter int VC_NUM     = 2**VC_SIZE,
  parameter int CREDIT_MAX = VC_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [VC_NUM-1:0]                 switch_request_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0]    downstream_vc_i,
  input  logic                              ready_i,
  input  logic [VC_NUM-1:0]                 credit_return_i,
  output logic [VC_NUM-1:0]                 read_o,
  output logic [VC_SIZE-1:0]                sel_vc_o,
  output logic                              valid_o,
  output logic [VC_NUM-1:0]                 credit_avail_o,
  output logic                              error_o
);

  localparam int CW = $clog2(CREDIT_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

  logic [VC_NUM-1:0][CW-1:0] credit;
  logic [VC_NUM-1:0][CW-1:0] credit_next;
  logic [VC_NUM-1:0]         overflow;
  logic [VC_NUM-1:0]         credit_dec;
  logic [VC_NUM-1:0]         eligible;
  logic [VC_SIZE-1:0]        rr_ptr;
  logic [VC_SIZE-1:0]        winner;
  logic [VC_SIZE-1:0]        idx;
  logic                      found;
  logic                      grant;

  // A VC just read is excluded because its buffer status lags by one cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      eligible[i] = switch_request_i[i] &&
                    (credit[downstream_vc_i[i]] != '0) &&
                    !read_o[i];
    end
  end

  // Round-robin search starting just after the last winner, wrapping naturally
  // because VC_NUM is a power of two.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = '0;
    for (int off = 1; off <= VC_NUM; off++) begin
      idx = rr_ptr + VC_SIZE'(off);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    grant = found && ready_i;
  end

  always_comb begin
    credit_dec = '0;
    if (grant) begin
      credit_dec[downstream_vc_i[winner]] = 1'b1;
    end
  end

  // Return and decrement on the same counter cancel; a lone return at the
  // ceiling saturates and flags overflow.
  always_comb begin
    credit_next = credit;
    overflow    = '0;
    for (int j = 0; j < VC_NUM; j++) begin
      if (credit_return_i[j] && !credit_dec[j]) begin
        if (credit[j] == CMAX) begin
          overflow[j] = 1'b1;
        end else begin
          credit_next[j] = credit[j] + 1'b1;
        end
      end else if (credit_dec[j] && !credit_return_i[j]) begin
        credit_next[j] = credit[j] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_o   <= '0;
      valid_o  <= 1'b0;
      sel_vc_o <= '0;
      rr_ptr   <= VC_SIZE'(VC_NUM - 1);
      error_o  <= 1'b0;
      for (int j = 0; j < VC_NUM; j++) begin
        credit[j] <= CMAX;
      end
    end else begin
      credit <= credit_next;
      if (|overflow) begin
        error_o <= 1'b1;
      end
      if (grant) begin
        read_o         <= '0;
        read_o[winner] <= 1'b1;
        valid_o        <= 1'b1;
        sel_vc_o       <= winner;
        rr_ptr         <= winner;
      end else begin
        read_o  <= '0;
        valid_o <= 1'b0;
      end
    end
  end

  always_comb begin
    credit_avail_o = '0;
    for (int j = 0; j < VC_NUM; j++) begin
      credit_avail_o[j] = (credit[j] != '0);
    end
  end

  a_read_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(read_o));
  a_valid_match : assert property (@(posedge clk) disable iff (rst) valid_o == (|read_o));

endmodule

// File: tb/tb_input_vc_scheduler.sv
// Directed bench for input_vc_scheduler with hand-computed expectations
// (VC_SIZE=2, VC_NUM=4, CREDIT_MAX=4).
module tb_input_vc_scheduler;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req;
  logic [3:0][1:0] dvc;
  logic            ready;
  logic [3:0]      ret;
  logic [3:0]      read;
  logic [1:0]      sel;
  logic            valid;
  logic [3:0]      avail;
  logic            error;

  int n_chk  = 0;
  int n_fail = 0;

  input_vc_scheduler #(.VC_SIZE(2), .VC_DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .switch_request_i (req),
    .downstream_vc_i  (dvc),
    .ready_i          (ready),
    .credit_return_i  (ret),
    .read_o           (read),
    .sel_vc_o         (sel),
    .valid_o          (valid),
    .credit_avail_o   (avail),
    .error_o          (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ret = '0; ready = 1'b0; dvc = '0;
    step(); step();
    chk("rst_read",  32'(read),  32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_sel",   32'(sel),   32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_avail", 32'(avail), 32'hf);
    rst = 1'b0;
  endtask

  logic [3:0] s1_read [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] s1_sel  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] s2_read [8] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000,
                              4'b0100, 4'b0000, 4'b0100, 4'b0000};
  logic [3:0] s3_read [5] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0000};
  int grants;

  initial begin
    // Round robin over all four VCs; returns keep downstream VC 0 topped up.
    do_reset();
    req = 4'b1111; ready = 1'b1; ret = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s1_read",  32'(read),  32'(s1_read[i]));
      chk("s1_sel",   32'(sel),   32'(s1_sel[i]));
      chk("s1_valid", 32'(valid), 32'h1);
    end
    req = '0; ret = '0;
    step();
    chk("s1_idle_read",  32'(read),  32'h0);
    chk("s1_idle_valid", 32'(valid), 32'h0);
    chk("s1_sel_hold",   32'(sel),   32'h0);
    chk("s1_avail",      32'(avail), 32'hf);
    chk("s1_error",      32'(error), 32'h0);

    // Single requester drains downstream VC 1, one return buys one more grant.
    do_reset();
    req = 4'b0100; dvc[2] = 2'd1; ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("s2_read", 32'(read), 32'(s2_read[i]));
      chk("s2_sel",  32'(sel),  32'h2);
    end
    chk("s2_avail_empty", 32'(avail), 32'hd);
    ret = 4'b0010;
    step();
    chk("s2_ret_read",  32'(read),  32'h0);
    chk("s2_ret_avail", 32'(avail), 32'hf);
    ret = '0;
    step();
    chk("s2_extra_read",  32'(read),  32'h4);
    chk("s2_extra_valid", 32'(valid), 32'h1);
    chk("s2_avail_again", 32'(avail), 32'hd);
    step();
    chk("s2_after_read", 32'(read), 32'h0);
    step();
    chk("s2_after_read2", 32'(read), 32'h0);

    // Asynchronous reset in the middle of a grant cycle.
    ret = 4'b0010;
    step();
    ret = '0;
    step();
    chk("s6_pre_valid", 32'(valid), 32'h1);
    chk("s6_pre_avail", 32'(avail), 32'hd);
    rst = 1'b1;
    #1;
    chk("s6_async_read",  32'(read),  32'h0);
    chk("s6_async_valid", 32'(valid), 32'h0);
    chk("s6_async_sel",   32'(sel),   32'h0);
    chk("s6_async_avail", 32'(avail), 32'hf);

    // ready low blocks grants and leaves credits untouched.
    do_reset();
    req = 4'b0011; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s3_blk_read",  32'(read),  32'h0);
      chk("s3_blk_valid", 32'(valid), 32'h0);
      chk("s3_blk_avail", 32'(avail), 32'hf);
    end
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s3_read", 32'(read), 32'(s3_read[i]));
    end
    chk("s3_avail", 32'(avail), 32'he);
    req = '0; ret = 4'b0001;
    step();
    ret = '0;
    chk("s3_ret_avail", 32'(avail), 32'hf);
    chk("s3_ret_error", 32'(error), 32'h0);

    // Same-edge decrement and return on downstream VC 3 cancel out.
    do_reset();
    req = 4'b0001; dvc[0] = 2'd3; ready = 1'b1; ret = 4'b1000;
    step();
    ret = '0;
    chk("s4_read",  32'(read),  32'h1);
    chk("s4_error", 32'(error), 32'h0);
    chk("s4_avail", 32'(avail), 32'hf);
    grants = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (valid) grants++;
    end
    chk("s4_grants",      32'(grants), 32'd4);
    chk("s4_avail_empty", 32'(avail),  32'h7);
    chk("s4_error_end",   32'(error),  32'h0);

    // Return into a full counter sets a sticky error.
    do_reset();
    ret = 4'b0001;
    step();
    ret = '0;
    chk("s5_error_set", 32'(error), 32'h1);
    chk("s5_avail",     32'(avail), 32'hf);
    req = 4'b0001; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s5_error_hold", 32'(error), 32'h1);
    end
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/input_vc_scheduler.md
INPUT_VC_SCHEDULER -- requirements
Module: input_vc_scheduler

Interface
REQ-001 The block SHALL take parameter VC_NUM, default 2**VC_SIZE, the number of VC buffers at one input port.
REQ-002 The block SHALL take parameter CREDIT_MAX, default VC_DEPTH, the initial and maximum credits per downstream VC.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port switch_request_i  input  VC_NUM  bit i high while VC buffer i holds a flit with an allocated downstream VC.
REQ-006 Port downstream_vc_i  input  VC_NUM x VC_SIZE  downstream VC id allocated to VC buffer i.
REQ-007 Port ready_i  input  1  the output port has accepted this input for the current cycle; arbitration is enabled only when it is high.
REQ-008 Port credit_return_i  input  VC_NUM  one-cycle pulse on bit j returns one credit for downstream VC j.
REQ-009 Port read_o  output  VC_NUM  registered one-hot read strobe driven to read_i of the VC buffers.
REQ-010 Port sel_vc_o  output  VC_SIZE  registered index of the VC currently granted, for the crossbar mux.
REQ-011 Port valid_o  output  1  registered; high when read_o is non-zero.
REQ-012 Port credit_avail_o  output  VC_NUM  bit j high when the credit count of downstream VC j is greater than 0.
REQ-013 Port error_o  output  1  sticky flag for credit overflow.

Function
REQ-014 Credit counters SHALL be $clog2(CREDIT_MAX+1) bits wide, one per downstream VC.
REQ-015 VC i SHALL be eligible when switch_request_i[i] is high, the credit count of downstream_vc_i[i] is greater than 0, and read_o[i] is low this cycle; the read_o exclusion covers buffer status lagging one cycle.
REQ-016 When ready_i is high and at least one VC is eligible, the winner SHALL be the first eligible index found searching upward from rr_ptr+1, wrapping at VC_NUM-1 to 0.
REQ-017 On a grant to VC k the block SHALL register read_o = one-hot k, sel_vc_o = k and valid_o = 1 for exactly one cycle, giving 1-cycle latency from request to read, and SHALL set rr_ptr = k.
REQ-018 If ready_i is low or no VC is eligible, read_o SHALL be 0, valid_o SHALL be 0, and sel_vc_o and rr_ptr SHALL hold.
REQ-019 At most one grant SHALL be issued per cycle, and no VC SHALL be granted in two consecutive cycles.
REQ-020 A grant to VC k SHALL decrement the credit of downstream_vc_i[k] at the same edge that read_o is registered.
REQ-021 A credit_return_i[j] pulse SHALL increment credit j; several bits MAY be high in one cycle.
REQ-022 A simultaneous decrement and return on the same downstream VC SHALL leave its count unchanged.
REQ-023 A return to a counter already at CREDIT_MAX (without a same-cycle decrement) SHALL leave the count saturated at CREDIT_MAX and set error_o, which stays high until reset.
REQ-024 A counter at 0 SHALL never decrement, because REQ-015 makes such a VC ineligible.
REQ-025 Two VCs allocated the same downstream VC SHALL share that counter: only one grant per cycle, so at most one decrement per counter per cycle.
REQ-026 credit_avail_o SHALL be combinational from the current counter values.

Reset
REQ-027 While rst is high the block SHALL asynchronously force read_o=0, valid_o=0, sel_vc_o=0, error_o=0, rr_ptr=VC_NUM-1 (VC 0 has first priority) and all credits to CREDIT_MAX, so credit_avail_o is all ones.
REQ-028 Assertion of rst in the middle of a grant SHALL clear read_o within the same cycle, with no partial credit update.
REQ-029 The first grant after rst falls SHALL occur no earlier than the first rising edge at which rst is low.

Verification
REQ-030 Scenario: after reset, switch_request_i=4'b1111, all downstream_vc_i=0, ready_i=1 -> read_o sequence 0001, 0010, 0100, 1000, 0001 on consecutive grant cycles, with sel_vc_o 0,1,2,3,0.
REQ-031 Scenario: switch_request_i[2] high alone, downstream_vc_i[2]=1, CREDIT_MAX=4, no returns -> four grants in alternating cycles, then read_o stays 0 and credit_avail_o[1]=0; one credit_return_i[1] pulse -> exactly one further grant.
REQ-032 Scenario: ready_i low with requests pending -> read_o=0, valid_o=0 and credit values unchanged; ready_i rising -> grant on the next edge.
REQ-033 Scenario: grant decrementing downstream VC 3 in the same cycle as credit_return_i[3] -> count unchanged.
REQ-034 Scenario: credit_return_i[0] pulse while credit 0 = CREDIT_MAX -> error_o=1, held through later traffic until rst.
REQ-035 Scenario: rst asserted asynchronously while valid_o=1 -> read_o=0, valid_o=0 and credit_avail_o all ones before the next clock edge.
